// File: rtl/disp_vramrd.sv
// ---------------------------------------------------------------------------
// disp_vramrd -- frame-buffer read master for the display path.
//
// On each vertical-sync falling edge with the display enabled, the block
// latches the 64-byte aligned frame base, then reads one whole frame from
// VRAM over the AXI read channel in fixed-length INCR bursts. Every returned
// beat is written into the pixel FIFO. Bursts are only issued while the FIFO
// reports room for a full burst, so this side never overflows it.
//
// Optional feature macro: DISP_RRESP_CHECK_EN
//   defined     : any beat with RRESP != OKAY sets the sticky RD_ERR flag
//   not defined : RRESP is ignored and RD_ERR is tied low
//
// Ports
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   DISPON, DISPADDR      display enable and frame base byte address
//   DSP_VSYNC_X           active-low vsync, asynchronous to ACLK
//   AR*                   AXI read address channel (ARLEN/ARSIZE/ARBURST fixed)
//   R*                    AXI read data channel
//   FIFO_WR, FIFO_WDATA   registered pixel FIFO write port
//   FIFO_AFULL            FIFO cannot take another full burst
//   FRAME_LATE            one-cycle pulse: vsync arrived before frame end
//   RD_ERR                sticky read-error flag
//
// Handshakes: AR and R use standard AXI valid/ready. ARVALID and ARADDR stay
// stable from assertion until the cycle ARREADY is seen high. RREADY is held
// high for the whole data phase of the single outstanding burst, so every
// RVALID beat in that phase is accepted.
// ---------------------------------------------------------------------------
module disp_vramrd #(
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 480,
    parameter int BURST_LEN = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    input  logic        DSP_VSYNC_X,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic        FIFO_WR,
    output logic [31:0] FIFO_WDATA,
    input  logic        FIFO_AFULL,
    output logic        FRAME_LATE,
    output logic        RD_ERR
);

    localparam int                FRAME_WORDS   = H_PIXELS * V_LINES;
    localparam int                WCNT_W        = $clog2(FRAME_WORDS + 1);
    localparam logic [WCNT_W-1:0] FRAME_WORDS_C = WCNT_W'(FRAME_WORDS);
    localparam logic [28:0]       BURST_BYTES   = 29'(BURST_LEN * 4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ADDR  = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t            state_q;
    logic [2:0]        vs_sync_q;     // [0] stage1, [1] stage2, [2] stage3
    logic [28:0]       base_q;
    logic [28:0]       offset_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              restart_q;
    logic [31:0]       araddr_q;
    logic              arvalid_q;
    logic              rready_q;
    logic              fifo_wr_q;
    logic [31:0]       fifo_wdata_q;
    logic              frame_late_q;

    logic              vs_fall;
    logic              beat;
    logic              restart_now;
    logic [WCNT_W-1:0] wcnt_d;

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    assign ARADDR     = araddr_q;
    assign ARVALID    = arvalid_q;
    assign RREADY     = rready_q;
    assign FIFO_WR    = fifo_wr_q;
    assign FIFO_WDATA = fifo_wdata_q;
    assign FRAME_LATE = frame_late_q;

    // Falling edge seen between synchroniser stages 2 and 3.
    assign vs_fall     = ~vs_sync_q[1] & vs_sync_q[2];
    assign beat        = RVALID & rready_q;
    // A vsync landing on the RLAST cycle itself must still force a restart.
    assign restart_now = restart_q | vs_fall;
    // Saturating decrement: an over-long frame from the slave cannot wrap.
    assign wcnt_d      = (wcnt_q != '0) ? (wcnt_q - 1'b1) : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= S_IDLE;
            vs_sync_q    <= 3'b000;
            base_q       <= '0;
            offset_q     <= '0;
            wcnt_q       <= '0;
            restart_q    <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_wdata_q <= '0;
            frame_late_q <= 1'b0;
        end else begin
            vs_sync_q    <= {vs_sync_q[1:0], DSP_VSYNC_X};
            fifo_wr_q    <= 1'b0;
            frame_late_q <= 1'b0;

            // Vsync while a frame is still being fetched: flag it and remember
            // to restart once the current burst has fully drained.
            if (state_q != S_IDLE && vs_fall) begin
                frame_late_q <= 1'b1;
                restart_q    <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    // A pending restart behaves exactly like a fresh vs_fall,
                    // re-sampling DISPON and DISPADDR now.
                    if (vs_fall || restart_q) begin
                        restart_q <= 1'b0;
                        if (DISPON) begin
                            base_q   <= {DISPADDR[28:6], 6'b0};
                            offset_q <= '0;
                            wcnt_q   <= FRAME_WORDS_C;
                            state_q  <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!FIFO_AFULL) begin
                        arvalid_q <= 1'b1;
                        araddr_q  <= {3'b000, base_q + offset_q};
                        state_q   <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (beat) begin
                        fifo_wr_q    <= 1'b1;
                        fifo_wdata_q <= RDATA;
                        wcnt_q       <= wcnt_d;
                        if (RLAST) begin
                            rready_q <= 1'b0;
                            offset_q <= offset_q + BURST_BYTES;
                            if (restart_now) begin
                                restart_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end else if (!DISPON) begin
                                state_q <= S_IDLE;
                            end else if (wcnt_d == '0) begin
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_ISSUE;
                            end
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DISP_RRESP_CHECK_EN
    logic rd_err_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_err_q <= 1'b0;
        end else if (state_q == S_DATA && beat && RRESP != 2'b00) begin
            rd_err_q <= 1'b1;
        end
    end

    assign RD_ERR = rd_err_q;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^DISPADDR[5:0];
`else
    assign RD_ERR = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{RRESP, DISPADDR[5:0]};
`endif

endmodule

// File: tb/tb_disp_vramrd.sv
// ---------------------------------------------------------------------------
// Bench for disp_vramrd with a 32x2 frame and 16-beat bursts (4 bursts of
// 16 words per frame). A behavioural AXI slave answers read bursts with a
// running data pattern and checks the address channel; every accepted beat
// is queued and compared against the pixel FIFO write port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_disp_vramrd;

    localparam int HP = 32;
    localparam int VL = 2;
    localparam int BL = 16;
    localparam int FRAME = HP * VL;

    logic        ACLK;
    logic        ARESETN;
    logic        DISPON;
    logic [28:0] DISPADDR;
    logic        DSP_VSYNC_X;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        FIFO_WR;
    logic [31:0] FIFO_WDATA;
    logic        FIFO_AFULL;
    logic        FRAME_LATE;
    logic        RD_ERR;

    disp_vramrd #(.H_PIXELS(HP), .V_LINES(VL), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .DISPON(DISPON), .DISPADDR(DISPADDR),
        .DSP_VSYNC_X(DSP_VSYNC_X), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .FIFO_WR(FIFO_WR),
        .FIFO_WDATA(FIFO_WDATA), .FIFO_AFULL(FIFO_AFULL),
        .FRAME_LATE(FRAME_LATE), .RD_ERR(RD_ERR)
    );

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    int          words_at_ar[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_rbeats = 0;
    int          n_words  = 0;
    int          n_late   = 0;
    int          stall_cfg = 0;
    int          afull_cfg = 0;
    int          err_beat  = -1;
    logic [31:0] data_seed = 32'h1234_5678;

`ifdef DISP_RRESP_CHECK_EN
    localparam logic EXP_RD_ERR = 1'b1;
`else
    localparam logic EXP_RD_ERR = 1'b0;
`endif

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    function automatic logic [31:0] get_addr(input int k);
        return (k < addr_q.size()) ? addr_q[k] : 32'hDEAD_BEEF;
    endfunction

    function automatic int get_wat(input int k);
        return (k < words_at_ar.size()) ? words_at_ar[k] : -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input int b);
        RVALID = 1'b1;
        RDATA  = data_seed;
        data_seed = data_seed + 32'h0101_0103;
        RLAST  = (b == BL - 1);
        RRESP  = (err_beat >= 0 && n_rbeats == err_beat) ? 2'b10 : 2'b00;
    endtask

    task automatic pulse_vsync();
        @(negedge ACLK);
        DSP_VSYNC_X = 1'b0;
        repeat (4) @(negedge ACLK);
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic clear_stats();
        addr_q.delete();
        words_at_ar.delete();
        n_rbeats = 0;
        n_words  = 0;
        n_late   = 0;
    endtask

    task automatic wait_words(input int n, input int limit);
        int t = 0;
        while (n_words < n && t < limit) begin
            @(negedge ACLK);
            t++;
        end
        check("wait_words_timeout", 32'(n_words >= n), 32'd1);
    endtask

    task automatic wait_beats(input int n, input int limit);
        int t = 0;
        while (n_rbeats < n && t < limit) begin
            @(negedge ACLK);
            t++;
        end
        check("wait_beats_timeout", 32'(n_rbeats >= n), 32'd1);
    endtask

    // ---------------- AXI slave + FIFO monitor ----------------
    // Everything runs on the falling edge. Handshake flags are computed after
    // this edge's drives, so they describe what the next rising edge sees.
    initial begin : slave
        bit          ar_hs = 0;
        bit          r_hs  = 0;
        bit          busy  = 0;
        bit          ar_wait = 0;
        int          beat_i = 0;
        int          stall_left = 0;
        int          afull_left = 0;
        logic [31:0] ar_first = '0;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00;
        FIFO_AFULL = 1'b0;
        forever begin
            @(negedge ACLK);
            if (r_hs) begin
                exp_q.push_back(RDATA);
                n_rbeats++;
                if (RLAST) begin
                    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                    busy = 0;
                    if (addr_q.size() == 1 && afull_cfg > 0) begin
                        FIFO_AFULL = 1'b1;
                        afull_left = afull_cfg;
                    end
                end else begin
                    beat_i++;
                    drive_beat(beat_i);
                end
            end
            if (FIFO_WR) begin
                if (exp_q.size() == 0) begin
                    check("fifo_wr_extra", 32'd1, 32'd0);
                end else begin
                    check("fifo_wdata", FIFO_WDATA, exp_q.pop_front());
                end
                n_words++;
            end
            if (FRAME_LATE) n_late++;
            if (ar_hs) begin
                ARREADY = 1'b0;
                ar_wait = 0;
                busy    = 1;
                addr_q.push_back(ar_first);
                words_at_ar.push_back(n_rbeats);
                beat_i = 0;
                drive_beat(0);
            end else if (ARVALID) begin
                check("one_outstanding", 32'(busy), 32'd0);
                if (!ar_wait) begin
                    ar_wait    = 1;
                    ar_first   = ARADDR;
                    stall_left = stall_cfg;
                end else begin
                    check("araddr_stable", ARADDR, ar_first);
                end
                if (stall_left > 0) begin
                    stall_left--;
                    ARREADY = 1'b0;
                end else begin
                    ARREADY = 1'b1;
                end
            end
            if (afull_left > 0) begin
                check("arvalid_during_afull", 32'(ARVALID), 32'd0);
                afull_left--;
                if (afull_left == 0) FIFO_AFULL = 1'b0;
            end
            r_hs  = RVALID && RREADY;
            ar_hs = ARVALID && ARREADY;
        end
    end

    // ---------------- test sequence ----------------
    typedef struct {
        logic [28:0] dispaddr;
        int          stall;
        int          afull;
        logic [31:0] exp_addr0;
        int          exp_bursts;
        int          exp_words;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{29'h100_0040,  0,  0, 32'h0100_0040, 4, FRAME};
        vecs[1] = '{29'h000_007F,  0,  0, 32'h0000_0040, 4, FRAME};
        vecs[2] = '{29'h0AB_CDE5,  5,  0, 32'h00AB_CDC0, 4, FRAME};
        vecs[3] = '{29'h1FFF_FFC0, 0, 12, 32'h1FFF_FFC0, 4, FRAME};

        ARESETN = 1'b0; DISPON = 1'b0; DISPADDR = '0; DSP_VSYNC_X = 1'b1;
        repeat (3) @(negedge ACLK);
        check("rst_araddr",     ARADDR,           32'h0);
        check("rst_arvalid",    32'(ARVALID),     32'd0);
        check("rst_rready",     32'(RREADY),      32'd0);
        check("rst_fifo_wr",    32'(FIFO_WR),     32'd0);
        check("rst_fifo_wdata", FIFO_WDATA,       32'h0);
        check("rst_frame_late", 32'(FRAME_LATE),  32'd0);
        check("rst_rd_err",     32'(RD_ERR),      32'd0);
        check("arlen",          32'(ARLEN),       32'd15);
        check("arsize",         32'(ARSIZE),      32'd2);
        check("arburst",        32'(ARBURST),     32'd1);
        ARESETN = 1'b1;
        repeat (6) @(negedge ACLK);

        // Whole-frame fetches: base alignment, ARREADY stall, back-pressure,
        // and the 29-bit address wrap at the top of the address space.
        for (int i = 0; i < 4; i++) begin
            clear_stats();
            stall_cfg = vecs[i].stall;
            afull_cfg = vecs[i].afull;
            DISPADDR  = vecs[i].dispaddr;
            DISPON    = 1'b1;
            pulse_vsync();
            wait_words(vecs[i].exp_words, 3000);
            repeat (40) @(negedge ACLK);
            check("n_bursts", 32'(addr_q.size()), 32'(vecs[i].exp_bursts));
            for (int k = 0; k < vecs[i].exp_bursts; k++)
                check("araddr", get_addr(k),
                      (vecs[i].exp_addr0 + 32'(k * BL * 4)) & 32'h1FFF_FFFF);
            check("n_words", 32'(n_words), 32'(vecs[i].exp_words));
            check("exp_q_drained", 32'(exp_q.size()), 32'd0);
            check("no_frame_late", 32'(n_late), 32'd0);
        end
        stall_cfg = 0;
        afull_cfg = 0;
        check("rd_err_clean", 32'(RD_ERR), 32'd0);

        // Late vsync during burst 2: that burst finishes, then the frame
        // restarts at the newly programmed base.
        clear_stats();
        DISPADDR = 29'h020_0000;
        pulse_vsync();
        wait_beats(BL + 2, 1000);
        DISPADDR = 29'h030_0040;
        pulse_vsync();
        wait_words(2 * BL + FRAME, 3000);
        repeat (40) @(negedge ACLK);
        check("late_pulses",     32'(n_late), 32'd1);
        check("late_n_bursts",   32'(addr_q.size()), 32'd6);
        check("late_burst2",     get_addr(1), 32'h0020_0040);
        check("late_burst2_len", 32'(get_wat(2)), 32'(2 * BL));
        check("late_restart",    get_addr(2), 32'h0030_0040);
        check("late_last",       get_addr(5), 32'h0030_0100);
        check("late_words",      32'(n_words), 32'(2 * BL + FRAME));

        // DISPON dropped mid-burst with an error response on one beat.
        clear_stats();
        err_beat = 5;
        DISPADDR = 29'h040_0000;
        pulse_vsync();
        wait_beats(BL + 4, 1000);
        DISPON = 1'b0;
        wait_words(2 * BL, 1000);
        repeat (60) @(negedge ACLK);
        err_beat = -1;
        check("drop_n_bursts", 32'(addr_q.size()), 32'd2);
        check("drop_words",    32'(n_words), 32'(2 * BL));
        check("rd_err",        32'(RD_ERR), 32'(EXP_RD_ERR));

        // Vsync with the display disabled is ignored; RD_ERR stays sticky.
        pulse_vsync();
        repeat (60) @(negedge ACLK);
        check("off_vsync_bursts", 32'(addr_q.size()), 32'd2);
        check("rd_err_sticky",    32'(RD_ERR), 32'(EXP_RD_ERR));
        check("off_no_late",      32'(n_late), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/disp_vramrd.md
# disp_vramrd

Frame-buffer read master for the display path, sitting directly downstream of the display register block. On each vertical-sync falling edge, if display is enabled, it latches the programmed frame base address. It then streams one full frame from VRAM over the AXI read channel in fixed-length bursts and writes every returned word into the pixel FIFO that feeds the display timing stage. FIFO back-pressure throttles burst issue, so the FIFO never overflows from this side.

## Interface
Parameters:
- H_PIXELS, 640, pixels per line (one 32-bit word per pixel)
- V_LINES, 480, lines per frame
- BURST_LEN, 16, beats per AXI burst; power of two, 2..256; H_PIXELS*V_LINES must be a multiple of it

Ports:
- ACLK  in  1  system clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous and active-low; clears all state and outputs immediately
- DISPON  in  1  display enable from register block
- DISPADDR  in  29  frame base byte address from register block
- DSP_VSYNC_X  in  1  vertical sync, active-low, from display timing domain (asynchronous to ACLK)
- ARADDR  out  32  AXI read address
- ARLEN  out  8  constant BURST_LEN-1
- ARSIZE  out  3  constant 3'b010
- ARBURST  out  2  constant 2'b01 (INCR)
- ARVALID  out  1  address valid
- ARREADY  in  1  address ready
- RDATA  in  32  read data
- RRESP  in  2  read response
- RLAST  in  1  last beat
- RVALID  in  1  read valid
- RREADY  out  1  read ready
- FIFO_WR  out  1  pixel FIFO write strobe
- FIFO_WDATA  out  32  pixel FIFO write data
- FIFO_AFULL  in  1  FIFO free space < BURST_LEN+1 words
- FRAME_LATE  out  1  one-cycle pulse: vsync arrived before frame finished
- RD_ERR  out  1  sticky read-error flag (see Configuration)

## Operation
- VSYNC handling: 3-stage synchroniser on DSP_VSYNC_X. vs_fall = stage2 low AND stage3 high.
- Word counter: counts words left in frame, loaded with H_PIXELS*V_LINES. Byte offset counter: advances by BURST_LEN*4 per accepted burst.
- States:
  - IDLE: all handshakes low. On vs_fall with DISPON=1: latch base = {DISPADDR[28:6], 6'b0}, clear offset, load word count, go to ISSUE.
  - ISSUE: if FIFO_AFULL=1, wait. Else assert ARVALID with ARADDR = {3'b000, base+offset}, go to ADDR.
  - ADDR: hold ARVALID and ARADDR stable until ARREADY=1, then go to DATA.
  - DATA: RREADY=1. Each RVALID beat is written to the FIFO and decrements the word count. On the RLAST beat, advance the offset and choose the next state in this order:
    - restart pending: go to IDLE-restart.
    - DISPON=0: go to IDLE.
    - word count = 0: go to IDLE.
    - otherwise: go to ISSUE.
- IDLE-restart: the IDLE entry taken when a restart is pending. The new frame starts immediately, as if vs_fall had just occurred. DISPADDR and DISPON are re-sampled at that point.
- vs_fall outside IDLE: pulse FRAME_LATE and set restart pending. The current burst always completes; no burst is ever truncated.
- DISPON dropping mid-frame: the current burst completes, then the block returns to IDLE. No further AR is issued.
- vs_fall in IDLE with DISPON=0: ignored.
- RLAST arriving before BURST_LEN beats: treated as burst end. The word count reflects the beats actually received.

## Timing
- Reset values: ARADDR=0, ARVALID=0, RREADY=0, FIFO_WR=0, FIFO_WDATA=0, FRAME_LATE=0, RD_ERR=0; state IDLE, synchroniser=0. ARLEN, ARSIZE and ARBURST are constants.
- vs_fall is detected 3 ACLK cycles after the DSP_VSYNC_X falling edge reaches the synchroniser.
- IDLE to first ARVALID: 2 cycles after vs_fall (IDLE → ISSUE → ARVALID registered), provided FIFO_AFULL=0.
- FIFO_WR and FIFO_WDATA are registered, 1 cycle after the RVALID&RREADY beat.
- RLAST beat to next ARVALID: 2 cycles minimum.
- Only one outstanding burst at any time.
- FIFO_AFULL is sampled only in ISSUE. Once a burst is issued, its data is always accepted.

## Configuration
- DISP_RRESP_CHECK_EN defined:
  - Any beat with RRESP≠2'b00 sets RD_ERR. RD_ERR stays set until ARESETN is asserted.
  - Data is still written to the FIFO unchanged.
- Not defined: RRESP is ignored and RD_ERR is tied to 0.

## Test plan
- Use H_PIXELS=32, V_LINES=2, BURST_LEN=16 unless noted.
- Frame fetch: DISPON=1, DISPADDR=0x1000040, vs_fall, ARREADY and RVALID always 1 → 4 bursts at ARADDR 0x01000040, 0x01000080, 0x010000C0, 0x01000100; 64 FIFO_WR pulses with data matching RDATA; return to IDLE.
- Alignment: DISPADDR=0x000007F → first ARADDR=0x00000040.
- Back-pressure: FIFO_AFULL=1 after the first burst → ARVALID stays 0 until FIFO_AFULL=0; no data lost; total FIFO_WR = 64.
- ARREADY stall: ARREADY held 0 for 5 cycles → ARVALID and ARADDR stable throughout; exactly one address handshake per burst.
- Late vsync: second vs_fall during burst 2 → FRAME_LATE pulses once; burst 2 completes all 16 beats; next ARADDR = new base + 0.
- DISPON drop mid-burst, plus error check:
  - DISPON dropped mid-burst → burst completes, no further ARVALID.
  - With DISP_RRESP_CHECK_EN defined, RRESP=2'b10 on one beat → RD_ERR=1 and it stays set.
